// File: rtl/casper400g_pkg.sv
// ----------------------------------------------------------------------------
// casper400g_pkg
// Shared types for the 400G transmit packetizer:
//   DATA_W / KEEP_W : user/AXIS data and byte-enable widths
//   fifo_word_t     : one buffered word {last, keep, data}
//   wr_state_e      : write-side packet FSM states
// ----------------------------------------------------------------------------
package casper400g_pkg;

   localparam int DATA_W = 512;
   localparam int KEEP_W = DATA_W / 8;

   typedef struct packed {
      logic              last;
      logic [KEEP_W-1:0] keep;
      logic [DATA_W-1:0] data;
   } fifo_word_t;

   typedef enum logic [1:0] {
      WR_IDLE = 2'd0,
      WR_PKT  = 2'd1,
      WR_DROP = 2'd2
   } wr_state_e;

endpackage

// File: rtl/casper400g_tx_ram.sv
// ----------------------------------------------------------------------------
// casper400g_tx_ram
// Simple dual-port RAM, DEPTH x WIDTH, one write port and one read port with a
// registered read (data valid the cycle after re_i). The read register holds
// its value while re_i is low, which the packetizer relies on as a stall stage.
//   clk_i            : clock
//   we_i/waddr_i/wdata_i : write port
//   re_i/raddr_i/rdata_o : read port, 1-cycle latency
// ----------------------------------------------------------------------------
module casper400g_tx_ram #(
   parameter int DEPTH  = 512,
   parameter int WIDTH  = 577,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [WIDTH-1:0]  wdata_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [WIDTH-1:0]  rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   // NOTE: the array and its read register have no reset; storage contents are
   // only ever consumed behind pointers that are reset, so they map onto block RAM.
   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      if (re_i) rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/casper400g_tx_packetizer.sv
// ----------------------------------------------------------------------------
// casper400g_tx_packetizer
// Store-and-forward TX packetizer: user words are written speculatively into a
// commit/rewind FIFO and only complete packets are replayed to the 400G MAC as
// AXI-Stream, so the MAC never underflows mid-packet. Oversize packets,
// packets that hit a full buffer, and packets ending with an empty keep are
// dropped whole and counted.
//   axis_clk, axis_reset_n           : clock, async active-low reset
//   Enable                           : sampled on the first word of a packet
//   tx_data/keep/valid/eof           : user input, no backpressure
//   tx_almost_full                   : free words < MAX_PKT_WORDS
//   tx_overflow                      : sticky, a packet was dropped for space
//   axis_tx_t*                       : AXIS master toward the MAC
//   counters_reset                   : sync clear of counters and tx_overflow
//   tx_packet_count / tx_drop_count  : 32-bit wrapping counters
// DATA_W/KEEP_W must match the widths carried by casper400g_pkg::fifo_word_t.
// ----------------------------------------------------------------------------
module casper400g_tx_packetizer #(
   parameter int DATA_W        = 512,
   parameter int KEEP_W        = 64,
   parameter int DEPTH         = 512,
   parameter int MAX_PKT_WORDS = 144
) (
   input  logic              axis_clk,
   input  logic              axis_reset_n,
   input  logic              Enable,
   input  logic [DATA_W-1:0] tx_data,
   input  logic [KEEP_W-1:0] tx_keep,
   input  logic              tx_valid,
   input  logic              tx_eof,
   output logic              tx_almost_full,
   output logic              tx_overflow,
   output logic [DATA_W-1:0] axis_tx_tdata,
   output logic              axis_tx_tvalid,
   output logic [KEEP_W-1:0] axis_tx_tkeep,
   output logic              axis_tx_tlast,
   output logic              axis_tx_tuser,
   input  logic              axis_tx_tready,
   input  logic              counters_reset,
   output logic [31:0]       tx_packet_count,
   output logic [31:0]       tx_drop_count
);

   import casper400g_pkg::fifo_word_t, casper400g_pkg::wr_state_e;
   import casper400g_pkg::WR_IDLE, casper400g_pkg::WR_PKT, casper400g_pkg::WR_DROP;

   localparam int ADDR_W = $clog2(DEPTH);
   localparam int PTR_W  = ADDR_W + 1;
   localparam int CNT_W  = $clog2(MAX_PKT_WORDS + 2);
   localparam logic [PTR_W-1:0] AF_THRESH = PTR_W'(DEPTH - MAX_PKT_WORDS);

   wr_state_e        state_q, state_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, fetch_ptr_q, fetch_ptr_d;
   logic [CNT_W-1:0] wcnt_q, wcnt_d, wcnt_next;
   logic             overflow_q, overflow_d;
   logic [31:0]      pkt_cnt_q, pkt_cnt_d, drop_cnt_q, drop_cnt_d;
   logic             s1_vld_q, s1_vld_d, out_vld_q, out_vld_d;
   fifo_word_t       out_q, out_d, wr_word, rd_word;
   logic             accept, drop, drop_evt, ovf_evt, ram_we, ram_re, adv_out, beat;
   logic [PTR_W-1:0] used;
   logic             full;

   // rd_ptr only retires on an accepted beat, so words sitting in the read
   // pipeline still count as occupied; fetch_ptr is the RAM read address.
   assign used           = wr_ptr_q - rd_ptr_q;
   assign full           = (used == PTR_W'(DEPTH));
   assign tx_almost_full = (used > AF_THRESH);

   // ---------------- write side ----------------
   always_comb begin
      // NOTE: every value written here gets a default first, so no path can
      // leave a signal unassigned and infer a latch.
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      commit_ptr_d = commit_ptr_q;
      wcnt_d       = wcnt_q;
      ram_we       = 1'b0;
      drop_evt     = 1'b0;
      ovf_evt      = 1'b0;
      wcnt_next    = (state_q == WR_IDLE) ? CNT_W'(1) : wcnt_q + 1'b1;
      accept       = tx_valid && ((state_q == WR_PKT) || ((state_q == WR_IDLE) && Enable));
      drop         = full || (wcnt_next > CNT_W'(MAX_PKT_WORDS)) || (tx_eof && (tx_keep == '0));
      wr_word.last = tx_eof;
      wr_word.keep = tx_eof ? tx_keep : '1;
      wr_word.data = tx_data;
      case (state_q)
         WR_DROP: begin
            if (tx_valid && tx_eof) state_d = WR_IDLE;
         end
         WR_IDLE, WR_PKT: begin
            if (accept) begin
               if (drop) begin
                  // Rewind discards the partial packet; the MAC never sees it.
                  wr_ptr_d = commit_ptr_q;
                  drop_evt = 1'b1;
                  ovf_evt  = full;
                  state_d  = tx_eof ? WR_IDLE : WR_DROP;
               end else begin
                  ram_we   = 1'b1;
                  wr_ptr_d = wr_ptr_q + 1'b1;
                  wcnt_d   = wcnt_next;
                  if (tx_eof) begin
                     commit_ptr_d = wr_ptr_q + 1'b1;
                     state_d      = WR_IDLE;
                  end else begin
                     state_d = WR_PKT;
                  end
               end
            end
         end
         default: state_d = WR_IDLE;
      endcase
   end

   // ---------------- read side ----------------
   // Two stages: the RAM read register (s1) and the AXIS output register.
   // s1 only reloads when it can hand its word on, so it doubles as the skid
   // stage that keeps tvalid continuous at one word per cycle.
   always_comb begin
      adv_out     = !out_vld_q || axis_tx_tready;
      beat        = out_vld_q && axis_tx_tready;
      ram_re      = (fetch_ptr_q != commit_ptr_q) && (!s1_vld_q || adv_out);
      fetch_ptr_d = fetch_ptr_q + PTR_W'(ram_re);
      rd_ptr_d    = rd_ptr_q + PTR_W'(beat);
      s1_vld_d    = ram_re || (s1_vld_q && !adv_out);
      out_vld_d   = adv_out ? s1_vld_q : out_vld_q;
      out_d       = (adv_out && s1_vld_q) ? rd_word : out_q;
   end

   // ---------------- counters ----------------
   always_comb begin
      pkt_cnt_d  = pkt_cnt_q;
      drop_cnt_d = drop_cnt_q;
      overflow_d = overflow_q;
      if (counters_reset) begin
         pkt_cnt_d  = '0;
         drop_cnt_d = '0;
         overflow_d = 1'b0;
      end else begin
         if (beat && out_q.last) pkt_cnt_d = pkt_cnt_q + 32'd1;
         if (drop_evt) drop_cnt_d = drop_cnt_q + 32'd1;
         if (ovf_evt) overflow_d = 1'b1;
      end
   end

   // NOTE: non-blocking assignments, so every register samples pre-edge values
   // regardless of statement order.
   always_ff @(posedge axis_clk or negedge axis_reset_n) begin
      if (!axis_reset_n) begin
         state_q      <= WR_IDLE;
         wr_ptr_q     <= '0;
         commit_ptr_q <= '0;
         rd_ptr_q     <= '0;
         fetch_ptr_q  <= '0;
         wcnt_q       <= '0;
         overflow_q   <= 1'b0;
         pkt_cnt_q    <= '0;
         drop_cnt_q   <= '0;
         s1_vld_q     <= 1'b0;
         out_vld_q    <= 1'b0;
         out_q        <= '0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         commit_ptr_q <= commit_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         fetch_ptr_q  <= fetch_ptr_d;
         wcnt_q       <= wcnt_d;
         overflow_q   <= overflow_d;
         pkt_cnt_q    <= pkt_cnt_d;
         drop_cnt_q   <= drop_cnt_d;
         s1_vld_q     <= s1_vld_d;
         out_vld_q    <= out_vld_d;
         out_q        <= out_d;
      end
   end

   casper400g_tx_ram #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(fifo_word_t))
   ) u_ram (
      .clk_i   (axis_clk),
      .we_i    (ram_we),
      .waddr_i (wr_ptr_q[ADDR_W-1:0]),
      .wdata_i (wr_word),
      .re_i    (ram_re),
      .raddr_i (fetch_ptr_q[ADDR_W-1:0]),
      .rdata_o (rd_word)
   );

   assign axis_tx_tdata   = out_q.data;
   assign axis_tx_tkeep   = out_q.keep;
   assign axis_tx_tlast   = out_q.last;
   assign axis_tx_tvalid  = out_vld_q;
   assign axis_tx_tuser   = 1'b0;
   assign tx_overflow     = overflow_q;
   assign tx_packet_count = pkt_cnt_q;
   assign tx_drop_count   = drop_cnt_q;

endmodule

// File: tb/tb_casper400g_tx_packetizer.sv
// ----------------------------------------------------------------------------
// tb_casper400g_tx_packetizer
// Scoreboard bench: every word of a packet expected to reach the MAC is
// queued as it is driven; the monitor pops and compares on each AXIS beat and
// checks that a stalled beat holds its value.
// ----------------------------------------------------------------------------
module tb_casper400g_tx_packetizer;

   localparam int DW = 512;
   localparam int KW = 64;
   localparam int EW = DW + KW + 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          enable;
   logic [DW-1:0] tx_data;
   logic [KW-1:0] tx_keep;
   logic          tx_valid, tx_eof;
   logic          almost_full, overflow;
   logic [DW-1:0] tdata;
   logic [KW-1:0] tkeep;
   logic          tvalid, tlast, tuser, tready;
   logic          counters_reset;
   logic [31:0]   pkt_count, drop_count;

   always #5 clk = ~clk;

   casper400g_tx_packetizer dut (
      .axis_clk        (clk),
      .axis_reset_n    (rst_n),
      .Enable          (enable),
      .tx_data         (tx_data),
      .tx_keep         (tx_keep),
      .tx_valid        (tx_valid),
      .tx_eof          (tx_eof),
      .tx_almost_full  (almost_full),
      .tx_overflow     (overflow),
      .axis_tx_tdata   (tdata),
      .axis_tx_tvalid  (tvalid),
      .axis_tx_tkeep   (tkeep),
      .axis_tx_tlast   (tlast),
      .axis_tx_tuser   (tuser),
      .axis_tx_tready  (tready),
      .counters_reset  (counters_reset),
      .tx_packet_count (pkt_count),
      .tx_drop_count   (drop_count)
   );

   int            n_checks = 0;
   int            n_pass   = 0;
   int            beat_cnt = 0;
   bit            toggle   = 1'b0;
   logic [EW-1:0] sb [$];

   task automatic check(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // ---------------- monitor ----------------
   bit            stall_prev = 1'b0;
   logic [EW-1:0] held;

   always @(negedge clk) begin
      logic [EW-1:0] cur;
      cur = {tlast, tkeep, tdata};
      if (!rst_n) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            check("hold_tvalid", tvalid, 1);
            check("hold_word", cur, held);
         end
         if (tvalid && tready) begin
            beat_cnt++;
            check("tuser", tuser, 0);
            check("sb_has_entry", sb.size() > 0, 1);
            if (sb.size() > 0) check("beat_word", cur, sb.pop_front());
         end
         stall_prev = tvalid && !tready;
         held       = cur;
      end
   end

   // ---------------- drivers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
      if (toggle) tready = ~tready;
   endtask

   task automatic send_word(input bit last, input logic [KW-1:0] ekeep, input bit pass);
      logic [DW-1:0] d;
      logic [KW-1:0] k;
      for (int l = 0; l < DW / 32; l++) d[l*32 +: 32] = $urandom;
      k        = last ? ekeep : '1;
      tx_valid = 1'b1;
      tx_data  = d;
      tx_eof   = last;
      tx_keep  = k;
      if (pass) sb.push_back({last, k, d});
      tick();
      tx_valid = 1'b0;
      tx_eof   = 1'b0;
   endtask

   task automatic send_pkt(input int n, input logic [KW-1:0] ekeep, input bit pass, input int en_fall);
      for (int i = 0; i < n; i++) begin
         if (i == en_fall) enable = 1'b0;
         send_word(i == n - 1, ekeep, pass);
      end
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((sb.size() != 0 || tvalid) && n < 3000) begin
         tick();
         n++;
      end
      check("drain_in_time", n < 3000, 1);
      repeat (3) tick();
   endtask

   // ---------------- sequence ----------------
   int exp_pkt  = 0;
   int exp_drop = 0;
   int b0;

   initial begin
      rst_n = 1'b0; enable = 1'b1; tx_valid = 1'b0; tx_eof = 1'b0;
      tx_keep = '0; tx_data = '0; tready = 1'b1; counters_reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_tvalid", tvalid, 0);
      check("rst_tdata", tdata, 0);
      check("rst_pkt_count", pkt_count, 0);
      check("rst_drop_count", drop_count, 0);
      check("rst_almost_full", almost_full, 0);
      check("rst_overflow", overflow, 0);
      rst_n = 1'b1;
      repeat (2) tick();

      // 3-word packet; first beat 2 cycles after the eof write edge
      send_pkt(3, 64'h0000_0000_0000_FFFF, 1, -1);
      @(negedge clk); check("lat_e0", tvalid, 0);
      @(negedge clk); check("lat_e1", tvalid, 0);
      @(negedge clk); check("lat_e2", tvalid, 1);
      wait_drain();
      exp_pkt = 1;
      check("t1_pkt_count", pkt_count, exp_pkt);
      check("t1_beats", beat_cnt, 3);

      // 10 back-to-back single-word packets, tready toggling
      toggle = 1'b1;
      b0 = beat_cnt;
      for (int i = 0; i < 10; i++) send_word(1, '1 >> (i * 5), 1);
      wait_drain();
      toggle = 1'b0; tready = 1'b1;
      exp_pkt += 10;
      check("t2_pkt_count", pkt_count, exp_pkt);
      check("t2_beats", beat_cnt - b0, 10);

      // fill with tready=0: three 144-word packets fit, the fourth overflows
      tready = 1'b0;
      repeat (2) tick();
      b0 = beat_cnt;
      for (int p = 0; p < 3; p++) send_pkt(144, '1, 1, -1);
      check("t3_almost_full", almost_full, 1);
      for (int i = 0; i < 80; i++) send_word(0, '1, 0);
      check("t3_ovf_before", overflow, 0);
      send_word(0, '1, 0);
      check("t3_ovf_at_81", overflow, 1);
      check("t3_drop_at_81", drop_count, 1);
      for (int i = 81; i < 144; i++) send_word(i == 143, '1, 0);
      check("t3_no_beats_stalled", beat_cnt - b0, 0);
      tready = 1'b1;
      wait_drain();
      exp_pkt += 3; exp_drop = 1;
      check("t3_beats", beat_cnt - b0, 432);
      check("t3_pkt_count", pkt_count, exp_pkt);
      check("t3_drop_count", drop_count, exp_drop);
      check("t3_almost_full_clear", almost_full, 0);

      counters_reset = 1'b1;
      tick();
      counters_reset = 1'b0;
      exp_pkt = 0; exp_drop = 0;
      check("clr_pkt", pkt_count, 0);
      check("clr_drop", drop_count, 0);
      check("clr_overflow", overflow, 0);

      // oversize packet dropped, following packet intact
      send_pkt(145, '1, 0, -1);
      send_pkt(2, 64'h0F, 1, -1);
      wait_drain();
      exp_pkt = 1; exp_drop = 1;
      check("t4_drop_count", drop_count, exp_drop);
      check("t4_overflow", overflow, 0);
      check("t4_pkt_count", pkt_count, exp_pkt);

      // empty eof keep, multi-word and single-word
      b0 = beat_cnt;
      send_pkt(3, '0, 0, -1);
      send_pkt(1, '0, 0, -1);
      repeat (8) tick();
      exp_drop += 2;
      check("t5_drop_count", drop_count, exp_drop);
      check("t5_no_beats", beat_cnt - b0, 0);

      // Enable low for a whole packet, then falling mid-packet
      enable = 1'b0;
      send_pkt(4, '1, 0, -1);
      repeat (8) tick();
      check("t6_ign_beats", beat_cnt - b0, 0);
      check("t6_ign_pkt", pkt_count, exp_pkt);
      check("t6_ign_drop", drop_count, exp_drop);
      enable = 1'b1;
      send_pkt(5, 64'h3, 1, 2);
      wait_drain();
      enable = 1'b1;
      exp_pkt += 1;
      check("t6_fall_pkt", pkt_count, exp_pkt);

      // async reset with a committed packet waiting
      tready = 1'b0;
      send_pkt(6, '1, 0, -1);
      repeat (3) tick();
      check("t7_pre_tvalid", tvalid, 1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("t7_tvalid", tvalid, 0);
      check("t7_tdata", tdata, 0);
      check("t7_tlast", tlast, 0);
      check("t7_tkeep", tkeep, 0);
      check("t7_pkt_count", pkt_count, 0);
      check("t7_drop_count", drop_count, 0);
      repeat (2) tick();
      rst_n = 1'b1;
      tready = 1'b1;
      b0 = beat_cnt;
      repeat (5) tick();
      check("t7_fifo_empty", tvalid, 0);
      check("t7_no_beats", beat_cnt - b0, 0);
      send_pkt(4, 64'hFF, 1, -1);
      wait_drain();
      exp_pkt = 1; exp_drop = 0;
      check("t7_new_pkt", pkt_count, exp_pkt);
      check("t7_new_beats", beat_cnt - b0, 4);

      // counters_reset coincident with a tlast beat
      b0 = beat_cnt;
      send_pkt(1, '1, 1, -1);
      tick();
      tick();
      counters_reset = 1'b1;
      tick();
      counters_reset = 1'b0;
      check("t8_beat_taken", beat_cnt - b0, 1);
      check("t8_reset_wins", pkt_count, 0);
      send_pkt(1, '1, 1, -1);
      wait_drain();
      check("t8_count_resumes", pkt_count, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
